// File: rtl/game_timer.sv
// game_timer: MM:SS countdown that samples a divided tick as data in the 100 MHz domain.
// Optional feature macro GAME_TIMER_WARN_EN adds a registered warn output for the final ten seconds.
module game_timer #(
   parameter int TICK_HZ   = 100,
   parameter int START_MIN = 2,
   parameter int START_SEC = 0
) (
   input  logic       clk100MHz,
   input  logic       rst,
   input  logic       tick_clk,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       expired,
   output logic       timeout_pulse
`ifdef GAME_TIMER_WARN_EN
   ,
   output logic       warn
`endif
);

   localparam int            PW          = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
   localparam logic [PW-1:0] PRE_MAX     = PW'(TICK_HZ - 1);
   localparam logic [3:0]    P_MT        = 4'(START_MIN / 10);
   localparam logic [3:0]    P_MO        = 4'(START_MIN % 10);
   localparam logic [3:0]    P_ST        = 4'(START_SEC / 10);
   localparam logic [3:0]    P_SO        = 4'(START_SEC % 10);
   localparam bit            PRESET_ZERO = (START_MIN == 0) && (START_SEC == 0);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   state_t        state_q, state_d;
   logic          s1_q, s2_q, s3_q, tick_en_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    mt_q, mo_q, st_q, so_q;
   logic [3:0]    mt_d, mo_d, st_d, so_d;
   logic [3:0]    mt_dec, mo_dec, st_dec, so_dec;
   logic          sec_en, dec_zero;
   logic          running_q, expired_q, timeout_q;
`ifdef GAME_TIMER_WARN_EN
   logic          warn_q;

   function automatic logic in_warn(input logic [3:0] mt, input logic [3:0] mo,
                                    input logic [3:0] st, input logic [3:0] so);
      return (mt == 4'd0) && (mo == 4'd0) &&
             (((st == 4'd0) && (so != 4'd0)) || ((st == 4'd1) && (so == 4'd0)));
   endfunction
`endif

   // BCD borrow chain; a zero count is left untouched so the timer never underflows
   always_comb begin
      mt_dec = mt_q;
      mo_dec = mo_q;
      st_dec = st_q;
      so_dec = so_q;
      if ({mt_q, mo_q, st_q, so_q} != 16'h0000) begin
         if (so_q != 4'd0) begin
            so_dec = so_q - 4'd1;
         end else begin
            so_dec = 4'd9;
            if (st_q != 4'd0) begin
               st_dec = st_q - 4'd1;
            end else begin
               st_dec = 4'd5;
               if (mo_q != 4'd0) begin
                  mo_dec = mo_q - 4'd1;
               end else begin
                  mo_dec = 4'd9;
                  mt_dec = mt_q - 4'd1;
               end
            end
         end
      end
   end

   assign dec_zero = ({mt_dec, mo_dec, st_dec, so_dec} == 16'h0000);
   assign sec_en   = (state_q == RUN) && tick_en_q && (presc_q == PRE_MAX);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      mt_d    = mt_q;
      mo_d    = mo_q;
      st_d    = st_q;
      so_d    = so_q;
      if (clear) begin
         state_d = IDLE;
         presc_d = '0;
         mt_d    = P_MT;
         mo_d    = P_MO;
         st_d    = P_ST;
         so_d    = P_SO;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  presc_d = '0;
                  state_d = PRESET_ZERO ? EXPIRED : RUN;
               end
            end
            RUN: begin
               if (tick_en_q) presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + PW'(1);
               if (sec_en) begin
                  mt_d = mt_dec;
                  mo_d = mo_dec;
                  st_d = st_dec;
                  so_d = so_dec;
               end
               // reaching 00:00 outranks a simultaneous pause
               if (sec_en && dec_zero) state_d = EXPIRED;
               else if (pause && !start) state_d = PAUSED;
            end
            PAUSED: begin
               if (start) state_d = RUN;
            end
            EXPIRED: state_d = EXPIRED;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk100MHz) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         tick_en_q <= 1'b0;
         state_q   <= IDLE;
         presc_q   <= '0;
         mt_q      <= P_MT;
         mo_q      <= P_MO;
         st_q      <= P_ST;
         so_q      <= P_SO;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         timeout_q <= 1'b0;
`ifdef GAME_TIMER_WARN_EN
         warn_q    <= 1'b0;
`endif
      end else begin
         s1_q      <= tick_clk;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         tick_en_q <= s2_q & ~s3_q;
         state_q   <= state_d;
         presc_q   <= presc_d;
         mt_q      <= mt_d;
         mo_q      <= mo_d;
         st_q      <= st_d;
         so_q      <= so_d;
         running_q <= (state_d == RUN);
         expired_q <= (state_d == EXPIRED);
         timeout_q <= (state_d == EXPIRED) && (state_q != EXPIRED);
`ifdef GAME_TIMER_WARN_EN
         warn_q    <= ((state_d == RUN) || (state_d == PAUSED)) && in_warn(mt_d, mo_d, st_d, so_d);
`endif
      end
   end

   assign min_tens      = mt_q;
   assign min_ones      = mo_q;
   assign sec_tens      = st_q;
   assign sec_ones      = so_q;
   assign running       = running_q;
   assign expired       = expired_q;
   assign timeout_pulse = timeout_q;
`ifdef GAME_TIMER_WARN_EN
   assign warn          = warn_q;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: five presets share one stimulus stream; the 10:00 instance is tracked by a scoreboard.
module tb_game_timer;

   localparam int N    = 5;
   localparam int THZ  = 4;
   localparam int PMIN [N] = '{1, 10, 0, 0, 0};
   localparam int PSEC [N] = '{5, 0, 2, 0, 12};
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick_clk = 1'b0;
   logic start = 1'b0, pause = 1'b0, clear = 1'b0;
   logic [3:0] mt [N];
   logic [3:0] mo [N];
   logic [3:0] st [N];
   logic [3:0] so [N];
   logic run [N];
   logic exp_o [N];
   logic to [N];
`ifdef GAME_TIMER_WARN_EN
   logic wn [N];
`endif

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int e_cnt = 0;
   bit sb_en = 1'b0;
   logic [15:0] a_prev;

   typedef struct { int cyc; logic [15:0] dig; } sb_t;
   sb_t sb_q [$];

   int m_st = M_IDLE, m_secs = 600, m_presc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : gen_dut
      game_timer #(.TICK_HZ(THZ), .START_MIN(PMIN[g]), .START_SEC(PSEC[g])) u_dut (
         .clk100MHz(clk), .rst(rst), .tick_clk(tick_clk),
         .start(start), .pause(pause), .clear(clear),
         .min_tens(mt[g]), .min_ones(mo[g]), .sec_tens(st[g]), .sec_ones(so[g]),
         .running(run[g]), .expired(exp_o[g]), .timeout_pulse(to[g])
`ifdef GAME_TIMER_WARN_EN
         , .warn(wn[g])
`endif
      );
   end

   function automatic logic [15:0] dig(input int g);
      return {mt[g], mo[g], st[g], so[g]};
   endfunction

   function automatic logic [15:0] bcd(input int s);
      int m, c;
      m = s / 60;
      c = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [15:0] d);
      sb_t e;
      e.cyc = c;
      e.dig = d;
      sb_q.push_back(e);
   endtask

   // digit changes of the 10:00 instance must match queued expectations, value and cycle
   always @(negedge clk) begin : mon
      sb_t e;
      if (sb_en && dig(1) !== a_prev) begin
         if (sb_q.size() == 0) begin
            check("sb_extra", dig(1), a_prev);
         end else begin
            e = sb_q.pop_front();
            check("sb_dig", dig(1), e.dig);
            check("sb_cyc", cyc, e.cyc);
         end
      end
      if (to[2] === 1'b1) begin
         e_cnt <= e_cnt + 1;
         check("e_pulse_dig", dig(2), 16'h0000);
         check("e_pulse_exp", exp_o[2], 1);
      end
      a_prev <= dig(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_ctrl(input logic s, input logic p, input logic c);
      if (c) begin
         if (m_secs != 600) push(cyc + 1, bcd(600));
         m_secs = 600; m_presc = 0; m_st = M_IDLE;
      end else begin
         case (m_st)
            M_IDLE:   if (s) begin m_st = M_RUN; m_presc = 0; end
            M_RUN:    if (p && !s) m_st = M_PAUSED;
            M_PAUSED: if (s) m_st = M_RUN;
            default:  ;
         endcase
      end
   endtask

   task automatic pulse(input logic s, input logic p, input logic c);
      start = s; pause = p; clear = c;
      model_ctrl(s, p, c);
      step(1);
      start = 1'b0; pause = 1'b0; clear = 1'b0;
   endtask

   task automatic tick_up();
      tick_clk = 1'b1;
      if (m_st == M_RUN) begin
         m_presc++;
         if (m_presc == THZ) begin
            m_presc = 0;
            m_secs--;
            push(cyc + 4, bcd(m_secs));
            if (m_secs == 0) m_st = M_EXP;
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         tick_up();
         step(20);
         tick_clk = 1'b0;
         step(20);
      end
   endtask

   task automatic tick_sec_pause();
      tick_up();
      step(3);
      pause = 1'b1;
      model_ctrl(1'b0, 1'b1, 1'b0);
      step(1);
      pause = 1'b0;
      step(16);
      tick_clk = 1'b0;
      step(20);
   endtask

   initial begin
      int base;
      step(3);
      check("rst_r_dig", dig(0), 16'h0105);
      check("rst_r_run", run[0], 0);
      check("rst_r_exp", exp_o[0], 0);
      check("rst_r_to", to[0], 0);
      check("rst_a_dig", dig(1), 16'h1000);
`ifdef GAME_TIMER_WARN_EN
      check("rst_w_warn", wn[4], 0);
`endif
      rst = 1'b0;
      sb_en = 1'b1;
      tick(10);
      check("idle_r_dig", dig(0), 16'h0105);

      pulse(1'b1, 1'b0, 1'b0);
      check("start_run", run[1], 1);
      tick(4);
      check("borrow_dig", dig(1), 16'h0959);

      tick(2);
      pulse(1'b0, 1'b1, 1'b0);
      check("pause_run", run[1], 0);
      tick(20);
      pulse(1'b1, 1'b0, 1'b0);
      tick(1);
      check("resume_hold", dig(1), 16'h0959);
      tick(1);
      check("resume_dec", dig(1), 16'h0958);

      tick(3);
      tick_sec_pause();
      check("coinc_dig", dig(1), 16'h0957);
      check("coinc_run", run[1], 0);
      tick(4);
      check("coinc_hold", dig(1), 16'h0957);

      pulse(1'b1, 1'b0, 1'b0);
      tick(2);
      pulse(1'b1, 1'b0, 1'b1);
      check("clr_run_dig", dig(1), 16'h1000);
      check("clr_run_run", run[1], 0);
      pulse(1'b1, 1'b0, 1'b0);
      tick(4);
      check("clr_after_dig", dig(1), 16'h0959);

      pulse(1'b0, 1'b0, 1'b1);
      base = e_cnt;
      pulse(1'b1, 1'b0, 1'b0);
      tick(7);
      check("e_pre_dig", dig(2), 16'h0001);
      check("e_pre_exp", exp_o[2], 0);
      check("e_pre_run", run[2], 1);
      tick(1);
      check("e_dig", dig(2), 16'h0000);
      check("e_exp", exp_o[2], 1);
      check("e_run", run[2], 0);
      check("e_pulses", e_cnt - base, 1);
      tick(4);
      pulse(1'b1, 1'b0, 1'b0);
      step(2);
      check("e_hold_dig", dig(2), 16'h0000);
      check("e_hold_exp", exp_o[2], 1);
      check("e_hold_pulses", e_cnt - base, 1);

      pulse(1'b1, 1'b0, 1'b1);
      check("clr_exp_dig", dig(2), 16'h0002);
      check("clr_exp_exp", exp_o[2], 0);
      check("clr_a_dig", dig(1), bcd(m_secs));
`ifdef GAME_TIMER_WARN_EN
      check("w_idle", wn[4], 0);
`endif

      pulse(1'b1, 1'b0, 1'b0);
      check("z_exp", exp_o[3], 1);
      check("z_pulse", to[3], 1);
      check("z_run", run[3], 0);
      step(1);
      check("z_pulse_end", to[3], 0);
      check("z_exp_hold", exp_o[3], 1);

`ifdef GAME_TIMER_WARN_EN
      tick(7);
      check("w_pre_dig", dig(4), 16'h0011);
      check("w_pre", wn[4], 0);
      tick_up();
      step(3);
      check("w_edge_m1", wn[4], 0);
      step(1);
      check("w_edge_dig", dig(4), 16'h0010);
      check("w_edge", wn[4], 1);
      step(16);
      tick_clk = 1'b0;
      step(20);
      pulse(1'b0, 1'b1, 1'b0);
      check("w_paused", wn[4], 1);
      pulse(1'b1, 1'b0, 1'b0);
      tick(40);
      check("w_exp", exp_o[4], 1);
      check("w_drop", wn[4], 0);
`endif

      step(10);
      check("sb_left", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
